// File: rtl/ul4.sv
// Registered bitwise logic unit: AND / OR / XOR / NOT-A on a and b, one-cycle latency.
// Optional registered zero flag on the result when UL4_ZERO_FLAG_EN is defined.
module ul4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef UL4_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    always_comb begin
        res = '0;
        unique case (s)
            2'b00: res = a & b;
            2'b01: res = a | b;
            2'b10: res = a ^ b;
            2'b11: res = ~a;
            default: res = '0;
        endcase
    end

    always_comb begin
        out_d   = en ? res : out_q;
        valid_d = en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

`ifdef UL4_ZERO_FLAG_EN
    logic zero_d, zero_q;

    // Tracks out_q: follows the new result when enabled, holds otherwise.
    always_comb begin
        zero_d = en ? (res == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_ul4.sv
// Self-checking bench for ul4: vector table, exhaustive sweep and reset corner cases.
// Zero-flag checks are compiled in only when UL4_ZERO_FLAG_EN is defined.
module tb_ul4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
    logic [3:0] out;
    logic       out_valid;
`ifdef UL4_ZERO_FLAG_EN
    logic       zero;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] out;
        logic       valid;
        logic       zero;
    } exp_t;

    typedef struct {
        string      name;
        logic       en;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] s;
        logic [3:0] exp_out;
        logic       exp_valid;
        logic       exp_zero;
    } vec_t;

    exp_t       sb[$];
    logic [3:0] model_out;

    ul4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .s         (s),
        .out       (out),
        .out_valid (out_valid)
`ifdef UL4_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] ref_op(input logic [1:0] sel, input logic [3:0] x,
                                          input logic [3:0] y);
        case (sel)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string name, input exp_t ex);
        chk({name, ".out"}, 32'(out), 32'(ex.out));
        chk({name, ".valid"}, 32'(out_valid), 32'(ex.valid));
`ifdef UL4_ZERO_FLAG_EN
        chk({name, ".zero"}, 32'(zero), 32'(ex.zero));
`endif
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic step(input string name, input logic e, input logic [3:0] ia,
                        input logic [3:0] ib, input logic [1:0] is, input exp_t ex);
        exp_t got;
        @(negedge clk);
        en = e;
        a  = ia;
        b  = ib;
        s  = is;
        sb.push_back(ex);
        model_out = ex.out;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_outputs(name, got);
    endtask

    task automatic step_model(input string name, input logic e, input logic [3:0] ia,
                              input logic [3:0] ib, input logic [1:0] is);
        exp_t ex;
        ex.out   = e ? ref_op(is, ia, ib) : model_out;
        ex.valid = e;
        ex.zero  = (ex.out == 4'b0000);
        step(name, e, ia, ib, is, ex);
    endtask

    initial begin
        vec_t vecs[8];
        exp_t rst_exp;

        vecs[0] = '{"and_0001_0000", 1'b1, 4'b0001, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1};
        vecs[1] = '{"or_0000_0001",  1'b1, 4'b0000, 4'b0001, 2'b01, 4'b0001, 1'b1, 1'b0};
        vecs[2] = '{"xor_0110_0001", 1'b1, 4'b0110, 4'b0001, 2'b10, 4'b0111, 1'b1, 1'b0};
        vecs[3] = '{"nota_0010",     1'b1, 4'b0010, 4'b0001, 2'b11, 4'b1101, 1'b1, 1'b0};
        vecs[4] = '{"hold_1101",     1'b0, 4'b1111, 4'b0000, 2'b00, 4'b1101, 1'b0, 1'b0};
        vecs[5] = '{"and_1111_1010", 1'b1, 4'b1111, 4'b1010, 2'b00, 4'b1010, 1'b1, 1'b0};
        vecs[6] = '{"nota_1111",     1'b1, 4'b1111, 4'b0110, 2'b11, 4'b0000, 1'b1, 1'b1};
        vecs[7] = '{"hold_0000",     1'b0, 4'b0101, 4'b1010, 2'b01, 4'b0000, 1'b0, 1'b1};

        rst_exp = '{4'b0000, 1'b0, 1'b1};
        model_out = 4'b0000;
        rst_n = 1'b0;
        en = 1'b0;
        a = 4'b0000;
        b = 4'b0000;
        s = 2'b00;

        #2;
        chk_outputs("reset_initial", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            exp_t ex;
            ex = '{vecs[i].exp_out, vecs[i].exp_valid, vecs[i].exp_zero};
            step(vecs[i].name, vecs[i].en, vecs[i].a, vecs[i].b, vecs[i].s, ex);
        end

        // Exhaustive sweep, with an idle cycle of random operands every 16 vectors.
        for (int si = 0; si < 4; si++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    step_model("sweep", 1'b1, 4'(ai), 4'(bi), 2'(si));
                end
                step_model("sweep_idle", 1'b0, 4'($urandom), 4'($urandom), 2'($urandom));
            end
        end

        // Reset mid-cycle after a result is present: clears without a clock.
        step_model("pre_reset", 1'b1, 4'b1111, 4'b0000, 2'b01);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs("reset_async", rst_exp);
        model_out = 4'b0000;

        // Enabled operands while in reset must be discarded across an edge.
        @(negedge clk);
        en = 1'b1;
        a = 4'b1010;
        b = 4'b0101;
        s = 2'b01;
        @(posedge clk);
        #1;
        chk_outputs("reset_hold", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;

        step_model("post_reset_xor", 1'b1, 4'b0101, 4'b0011, 2'b10);
        step_model("post_reset_b2b", 1'b1, 4'b1100, 4'b1010, 2'b00);
        step_model("post_reset_idle", 1'b0, 4'b0000, 4'b0000, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
